// File: rtl/pc_sequencer.sv
`default_nettype none
//============================================================================
//  Module   : pc_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute/step sequencer for the 8-bit
//             core's program-counter datapath. Issues one PC step for each
//             instruction, with the branch select and offset latched in
//             DECODE. Latches a fault on a fetch timeout, a PC overflow or
//             too many taken backward branches.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
//  Ports
//    clk        in   1  system clock, rising edge
//    reset      in   1  asynchronous reset, active-low
//    start      in   1  leave IDLE (only looked at in IDLE)
//    memReady   in   1  instr byte valid (only looked at in FETCH)
//    instr      in   8  instruction byte from instruction memory
//    condFlag   in   1  ALU condition for conditional branches (DECODE)
//    pcFlags    in   2  [1] PC adder overflow, [0] taken backward branch
//    memRead    out  1  fetch request, high throughout FETCH
//    irLoad     out  1  FETCH cycle in which memReady is high
//    pcStep     out  1  one-cycle PC advance enable (STEP)
//    sigBranch  out  1  branch select to PC datapath
//    adding     out  8  sign-extended branch offset to PC datapath
//    state      out  3  current state encoding
//    halted     out  1  high in HALT
//    fault      out  1  high in FAULT
//    faultCode  out  2  01 fetch timeout, 10 PC overflow, 11 loop limit
//============================================================================
module pc_sequencer #(
    parameter int         EXEC_CYCLES   = 2,      // 1..15
    parameter int         FETCH_TIMEOUT = 16,     // 1..255
    parameter int         LOOP_LIMIT    = 0,      // 0 disables the check
    parameter logic [7:0] HALT_OP       = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       memReady,
    input  logic [7:0] instr,
    input  logic       condFlag,
    input  logic [1:0] pcFlags,
    output logic       memRead,
    output logic       irLoad,
    output logic       pcStep,
    output logic       sigBranch,
    output logic [7:0] adding,
    output logic [2:0] state,
    output logic       halted,
    output logic       fault,
    output logic [1:0] faultCode
);

    // ------------------------------------------------------------------
    // State encoding (visible on the state port, so values are fixed)
    // ------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_DECODE = 3'd2;
    localparam logic [2:0] c_S_EXEC   = 3'd3;
    localparam logic [2:0] c_S_STEP   = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;
    localparam logic [2:0] c_S_FAULT  = 3'd6;

    localparam logic [1:0] c_FC_NONE    = 2'b00;
    localparam logic [1:0] c_FC_TIMEOUT = 2'b01;
    localparam logic [1:0] c_FC_OVF     = 2'b10;
    localparam logic [1:0] c_FC_LOOP    = 2'b11;

    // Terminal values of the down/up counters, sized to their registers
    localparam logic [3:0] c_EXEC_LAST  = 4'(EXEC_CYCLES - 1);
    localparam logic [7:0] c_TO_LAST    = 8'(FETCH_TIMEOUT - 1);
    localparam logic [7:0] c_LOOP_LIMIT = 8'(LOOP_LIMIT);
    localparam logic       c_LOOP_EN    = (LOOP_LIMIT != 0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [7:0] r_ir;
    logic [7:0] r_to_cnt;       // consecutive FETCH cycles without memReady
    logic [3:0] r_exec_cnt;     // EXEC cycles remaining minus one
    logic [7:0] r_loop_cnt;     // taken backward branches since start
    logic       r_sig_branch;
    logic [7:0] r_adding;
    logic [1:0] r_fault_code;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic       w_is_halt;
    logic       w_is_uncond;
    logic       w_is_cond;
    logic [7:0] w_offset;
    logic [7:0] w_loop_next;

    assign w_is_halt   = (r_ir == HALT_OP);
    assign w_is_uncond = (r_ir[7:6] == 2'b10);
    assign w_is_cond   = (r_ir[7:6] == 2'b11);
    // 6-bit signed offset sign-extended to the 8-bit PC width
    assign w_offset    = {r_ir[5], r_ir[5], r_ir[5:0]};
    // Loop counter saturates instead of wrapping back below the limit
    assign w_loop_next = (r_loop_cnt == 8'hFF) ? 8'hFF : r_loop_cnt + 8'd1;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_S_IDLE;
            r_ir         <= 8'h00;
            r_to_cnt     <= 8'h00;
            r_exec_cnt   <= 4'h0;
            r_loop_cnt   <= 8'h00;
            r_sig_branch <= 1'b0;
            r_adding     <= 8'h00;
            r_fault_code <= c_FC_NONE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state    <= c_S_FETCH;
                        r_to_cnt   <= 8'h00;
                        r_loop_cnt <= 8'h00;
                    end
                end

                c_S_FETCH: begin
                    // A byte arriving on the expiring cycle still wins
                    if (memReady) begin
                        r_ir    <= instr;
                        r_state <= c_S_DECODE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state      <= c_S_FAULT;
                        r_fault_code <= c_FC_TIMEOUT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end

                c_S_DECODE: begin
                    if (w_is_halt) begin
                        r_sig_branch <= 1'b0;
                        r_adding     <= 8'h00;
                        r_state      <= c_S_HALT;
                    end else if (w_is_uncond || (w_is_cond && condFlag)) begin
                        r_sig_branch <= 1'b1;
                        r_adding     <= w_offset;
                        r_state      <= c_S_STEP;
                    end else if (w_is_cond) begin
                        // Not-taken conditional: plain sequential step
                        r_sig_branch <= 1'b0;
                        r_adding     <= 8'h00;
                        r_state      <= c_S_STEP;
                    end else begin
                        r_sig_branch <= 1'b0;
                        r_adding     <= 8'h00;
                        r_exec_cnt   <= c_EXEC_LAST;
                        r_state      <= c_S_EXEC;
                    end
                end

                c_S_EXEC: begin
                    if (r_exec_cnt == 4'h0) begin
                        r_state <= c_S_STEP;
                    end else begin
                        r_exec_cnt <= r_exec_cnt - 4'h1;
                    end
                end

                c_S_STEP: begin
                    // The step itself happens this cycle regardless of the
                    // outcome; branch controls drop once it has been taken.
                    r_sig_branch <= 1'b0;
                    r_adding     <= 8'h00;
                    if (pcFlags[1]) begin
                        r_state      <= c_S_FAULT;
                        r_fault_code <= c_FC_OVF;
                    end else if (pcFlags[0] && c_LOOP_EN) begin
                        r_loop_cnt <= w_loop_next;
                        if (w_loop_next == c_LOOP_LIMIT) begin
                            r_state      <= c_S_FAULT;
                            r_fault_code <= c_FC_LOOP;
                        end else begin
                            r_state  <= c_S_FETCH;
                            r_to_cnt <= 8'h00;
                        end
                    end else begin
                        r_state  <= c_S_FETCH;
                        r_to_cnt <= 8'h00;
                    end
                end

                c_S_HALT, c_S_FAULT: begin
                    // Terminal until reset; faultCode is held
                end

                default: begin
                    // Unused encoding: recover to a clean idle
                    r_state      <= c_S_IDLE;
                    r_sig_branch <= 1'b0;
                    r_adding     <= 8'h00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign memRead   = (r_state == c_S_FETCH);
    assign irLoad    = (r_state == c_S_FETCH) && memReady;
    assign pcStep    = (r_state == c_S_STEP);
    assign sigBranch = r_sig_branch;
    assign adding    = r_adding;
    assign state     = r_state;
    assign halted    = (r_state == c_S_HALT);
    assign fault     = (r_state == c_S_FAULT);
    assign faultCode = r_fault_code;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/execute sequencer that drives the program counter datapath of the 8-bit core. It requests instruction fetches, latches each instruction, decodes the branch/halt class, waits out execution, and then issues exactly one PC step per instruction with the correct branch select and offset. It monitors the PC datapath flags (overflow, backward branch) and a fetch-timeout watchdog, and latches a fault when any of them trips.

Parameters:
EXEC_CYCLES, 2, cycles spent in EXEC for non-branch, non-halt instructions (legal range 1..15).
FETCH_TIMEOUT, 16, consecutive cycles in FETCH with memReady low that cause a fault (legal range 1..255).
LOOP_LIMIT, 0, number of taken backward branches since start that causes a fault; 0 disables the check.
HALT_OP, 8'h7F, opcode that halts the sequencer.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-low.
start  in  1  leave IDLE; sampled only in IDLE.
memReady  in  1  instruction byte valid on instr; sampled only in FETCH.
instr  in  8  instruction byte from instruction memory.
condFlag  in  1  ALU condition for conditional branch; sampled in DECODE.
pcFlags  in  2  PC datapath flags: [1] adder overflow, [0] taken backward branch; sampled in STEP.
memRead  out  1  fetch request, high throughout FETCH.
irLoad  out  1  high for the FETCH cycle in which memReady=1.
pcStep  out  1  PC advance enable, high for exactly one cycle (STEP).
sigBranch  out  1  branch select to PC datapath, registered in DECODE.
adding  out  8  branch offset to PC datapath, registered in DECODE.
state  out  3  current state encoding.
halted  out  1  high in HALT.
fault  out  1  high in FAULT.
faultCode  out  2  01 fetch timeout, 10 PC overflow, 11 loop limit; 00 otherwise.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, STEP=4, HALT=5, FAULT=6; Moore outputs decoded from registered state and registers only.
- reset low: immediately (asynchronously) state=IDLE, ir=0, sigBranch=0, adding=0, all counters=0, faultCode=00, all outputs 0. Reset mid-operation abandons the instruction; no pcStep is issued.
- IDLE: start=1 -> FETCH, clears loop counter. start is ignored in every other state.
- FETCH: memRead=1. memReady=1 -> ir<=instr, irLoad=1, -> DECODE. Timeout counter cleared on entry; memReady=0 increments it; memReady=0 while counter==FETCH_TIMEOUT-1 -> FAULT, faultCode=01. memReady=1 on the expiring cycle wins (no fault).
- DECODE (1 cycle), classification of ir:
  - ir==HALT_OP -> HALT; no pcStep.
  - ir[7:6]==2'b10: unconditional branch, sigBranch<=1, adding<={ir[5],ir[5],ir[5:0]} -> STEP.
  - ir[7:6]==2'b11: conditional branch; condFlag=1 -> as unconditional; condFlag=0 -> sigBranch<=0, adding<=0 -> STEP.
  - Otherwise: sigBranch<=0, adding<=0, exec counter loaded -> EXEC.
- EXEC: stays exactly EXEC_CYCLES cycles, then -> STEP.
- STEP (1 cycle): pcStep=1, and sigBranch/adding are held stable throughout.
  - pcFlags[1]=1 -> FAULT, faultCode=10. The PC still takes this step (it wraps).
  - Else, if pcFlags[0]=1 and LOOP_LIMIT!=0: the loop counter (saturating 8-bit) increments. Reaching LOOP_LIMIT -> FAULT, faultCode=11.
  - Else -> FETCH.
  - Overflow takes priority over the loop limit.
- sigBranch/adding return to 0 on leaving STEP.
- HALT and FAULT are terminal until reset; memReady, start and pcFlags are ignored there. faultCode holds its value in FAULT.
- memReady outside FETCH is ignored. pcFlags outside STEP is ignored.

Test Plan:
1. Reset, EXEC_CYCLES=2, start pulse, memReady=1 immediately, instr=8'h01 -> states FETCH, DECODE, EXEC, EXEC, STEP. pcStep=1 only in the 5th cycle after the start edge, with sigBranch=0 and adding=8'h00; then back to FETCH.
2. instr=8'hFC with condFlag=1 -> STEP with sigBranch=1, adding=8'hFC. Repeat with condFlag=0 -> sigBranch=0, adding=8'h00. instr=8'h85 -> sigBranch=1, adding=8'h05. No EXEC cycles in any of these cases.
3. instr=8'h7F -> HALT, halted=1, pcStep never asserted. A later start pulse leaves state=5.
4. FETCH_TIMEOUT=16 with memReady held 0 -> fault=1, faultCode=01 after the 16th FETCH cycle. Second run with memReady=1 on the 16th cycle -> DECODE, no fault.
5. pcFlags=2'b10 during STEP -> pcStep pulse still issued, then FAULT with faultCode=10. LOOP_LIMIT=3 with three branches each returning pcFlags[0]=1 -> FAULT with faultCode=11 after the third STEP; pcFlags=2'b11 in STEP -> faultCode=10.
6. reset driven low mid-EXEC, not aligned to clk -> state=0 and all outputs 0 before the next edge. After release with start=0, the sequencer stays in IDLE with memRead=0.
